// File: rtl/sync_marker_seq.sv
// Sync-marker transmitter: emits the INIT/TRAIN/VCTM/DELAY/TEXE/LEAK/SIM_EXIT
// marker stream as valid/inst/id commit beats, with optional gaps or fillers.
module sync_marker_seq #(
  parameter int TRAIN_ROUNDS = 2,
  parameter int GAP_W        = 8,
  parameter int ID_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [GAP_W-1:0] gap,
  input  logic             fill_nop,
  input  logic             skip_delay,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_inst,
  output logic [ID_W-1:0]  out_id,
  output logic             busy,
  output logic             done
);

  localparam int RND_W = (TRAIN_ROUNDS > 0) ? $clog2(TRAIN_ROUNDS + 1) : 1;

  localparam logic [3:0] K_VCTM_START  = 4'd0;
  localparam logic [3:0] K_VCTM_END    = 4'd1;
  localparam logic [3:0] K_DELAY_START = 4'd2;
  localparam logic [3:0] K_DELAY_END   = 4'd3;
  localparam logic [3:0] K_TEXE_START  = 4'd4;
  localparam logic [3:0] K_TEXE_END    = 4'd5;
  localparam logic [3:0] K_LEAK_START  = 4'd6;
  localparam logic [3:0] K_LEAK_END    = 4'd7;
  localparam logic [3:0] K_INIT_START  = 4'd8;
  localparam logic [3:0] K_INIT_END    = 4'd9;
  localparam logic [3:0] K_TRAIN_START = 4'd12;
  localparam logic [3:0] K_TRAIN_END   = 4'd13;
  localparam logic [3:0] K_SIM_EXIT    = 4'd14;

  localparam logic [31:0] FILLER_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       marker_reg, marker_next, marker_adv;
  logic [RND_W-1:0] round_reg, round_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [GAP_W-1:0] gap_cfg_reg, gap_cfg_next;
  logic             fill_cfg_reg, fill_cfg_next;
  logic             skip_cfg_reg, skip_cfg_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic             last_round;
  logic             accept;

  // slti x0, x0, k
  function automatic logic [31:0] encode_marker(input logic [3:0] k);
    return {8'h00, k, 20'h02013};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      marker_reg   <= K_INIT_START;
      round_reg    <= '0;
      gap_cnt_reg  <= '0;
      gap_cfg_reg  <= '0;
      fill_cfg_reg <= 1'b0;
      skip_cfg_reg <= 1'b0;
      id_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      marker_reg   <= marker_next;
      round_reg    <= round_next;
      gap_cnt_reg  <= gap_cnt_next;
      gap_cfg_reg  <= gap_cfg_next;
      fill_cfg_reg <= fill_cfg_next;
      skip_cfg_reg <= skip_cfg_next;
      id_reg       <= id_next;
    end
  end

  // The TRAIN_END being accepted right now closes the final round.
  assign last_round = (({1'b0, round_reg} + (RND_W + 1)'(1)) == (RND_W + 1)'(TRAIN_ROUNDS));

  always_comb begin
    marker_adv = K_SIM_EXIT;
    case (marker_reg)
      K_INIT_START:  marker_adv = K_INIT_END;
      K_INIT_END:    marker_adv = (TRAIN_ROUNDS > 0) ? K_TRAIN_START : K_VCTM_START;
      K_TRAIN_START: marker_adv = K_TRAIN_END;
      K_TRAIN_END:   marker_adv = last_round ? K_VCTM_START : K_TRAIN_START;
      K_VCTM_START:  marker_adv = skip_cfg_reg ? K_TEXE_START : K_DELAY_START;
      K_DELAY_START: marker_adv = K_DELAY_END;
      K_DELAY_END:   marker_adv = K_TEXE_START;
      K_TEXE_START:  marker_adv = K_TEXE_END;
      K_TEXE_END:    marker_adv = K_LEAK_START;
      K_LEAK_START:  marker_adv = K_LEAK_END;
      K_LEAK_END:    marker_adv = K_VCTM_END;
      K_VCTM_END:    marker_adv = K_SIM_EXIT;
      default:       marker_adv = K_SIM_EXIT;
    endcase
  end

  always_comb begin
    out_valid = (state_reg == ST_EMIT) || ((state_reg == ST_GAP) && fill_cfg_reg);
    out_inst  = '0;
    if (state_reg == ST_EMIT) begin
      out_inst = encode_marker(marker_reg);
    end else if ((state_reg == ST_GAP) && fill_cfg_reg) begin
      out_inst = FILLER_INST;
    end
    out_id = id_reg;
    busy   = (state_reg == ST_EMIT) || (state_reg == ST_GAP);
    done   = (state_reg == ST_DONE);
  end

  assign accept = out_valid && out_ready;

  always_comb begin
    state_next    = state_reg;
    marker_next   = marker_reg;
    round_next    = round_reg;
    gap_cnt_next  = gap_cnt_reg;
    gap_cfg_next  = gap_cfg_reg;
    fill_cfg_next = fill_cfg_reg;
    skip_cfg_next = skip_cfg_reg;
    id_next       = id_reg;

    if (abort) begin
      state_next   = ST_IDLE;
      gap_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            gap_cfg_next  = gap;
            fill_cfg_next = fill_nop;
            skip_cfg_next = skip_delay;
            marker_next   = K_INIT_START;
            round_next    = '0;
            gap_cnt_next  = '0;
            id_next       = '0;
            state_next    = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (accept) begin
            id_next = id_reg + ID_W'(1);
            if (marker_reg == K_SIM_EXIT) begin
              state_next = ST_DONE;
            end else begin
              // Advance now; the marker is not shown again during the gap.
              marker_next = marker_adv;
              if (marker_reg == K_TRAIN_END) begin
                round_next = round_reg + RND_W'(1);
              end
              if (gap_cfg_reg != '0) begin
                gap_cnt_next = gap_cfg_reg;
                state_next   = ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (!fill_cfg_reg || out_ready) begin
            gap_cnt_next = gap_cnt_reg - GAP_W'(1);
            if (fill_cfg_reg) begin
              id_next = id_reg + ID_W'(1);
            end
            if (gap_cnt_reg == GAP_W'(1)) begin
              state_next = ST_EMIT;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_marker_seq.sv
// Randomized bench for sync_marker_seq: a list-based model of the marker
// stream is compared beat by beat against two DUTs (TRAIN_ROUNDS=2 and 0).
module tb_sync_marker_seq;
  localparam int GAP_W = 8;
  localparam int ID_W  = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [GAP_W-1:0] gap = '0;
  logic             fill_nop = 1'b0;
  logic             skip_delay = 1'b0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b0;
  logic             sel = 1'b0;

  logic             start2, start0;
  logic             v2, v0, b2, b0, d2, d0;
  logic [31:0]      i2, i0;
  logic [ID_W-1:0]  id2, id0;
  logic             o_valid, o_busy, o_done;
  logic [31:0]      o_inst;
  logic [ID_W-1:0]  o_id;

  assign start2  = start & ~sel;
  assign start0  = start & sel;
  assign o_valid = sel ? v0 : v2;
  assign o_busy  = sel ? b0 : b2;
  assign o_done  = sel ? d0 : d2;
  assign o_inst  = sel ? i0 : i2;
  assign o_id    = sel ? id0 : id2;

  always #5 clock = ~clock;

  sync_marker_seq #(.TRAIN_ROUNDS(2), .GAP_W(GAP_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset), .start(start2), .gap(gap), .fill_nop(fill_nop),
    .skip_delay(skip_delay), .abort(abort), .out_ready(out_ready),
    .out_valid(v2), .out_inst(i2), .out_id(id2), .busy(b2), .done(d2)
  );

  sync_marker_seq #(.TRAIN_ROUNDS(0), .GAP_W(GAP_W), .ID_W(ID_W)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .gap(gap), .fill_nop(fill_nop),
    .skip_delay(skip_delay), .abort(abort), .out_ready(out_ready),
    .out_valid(v0), .out_inst(i0), .out_id(id0), .busy(b0), .done(d0)
  );

  int n_pass  = 0;
  int n_total = 0;
  int pat     = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Expected beat stream: marker list from the ordering rules, then fillers.
  function automatic void build_exp(input int rounds, input int g, input bit f, input bit s);
    int mk[$];
    logic [3:0] k;
    exp_q.delete();
    mk.push_back(8); mk.push_back(9);
    for (int r = 0; r < rounds; r++) begin
      mk.push_back(12); mk.push_back(13);
    end
    mk.push_back(0);
    if (!s) begin
      mk.push_back(2); mk.push_back(3);
    end
    mk.push_back(4); mk.push_back(5); mk.push_back(6); mk.push_back(7);
    mk.push_back(1); mk.push_back(14);
    foreach (mk[i]) begin
      k = 4'(mk[i]);
      exp_q.push_back({8'h00, k, 20'h02013});
      if (mk[i] != 14 && f) begin
        for (int j = 0; j < g; j++) exp_q.push_back(32'h0000_0013);
      end
    end
  endfunction

  function automatic bit pick_ready(input int mode);
    bit r;
    case (mode)
      0:       r = 1'b1;
      1:       r = (pat % 3) == 0;
      default: r = ($urandom_range(0, 3) != 0);
    endcase
    pat++;
    return r;
  endfunction

  task automatic pulse_start(input int g, input bit f, input bit s);
    @(negedge clock);
    gap = GAP_W'(g); fill_nop = f; skip_delay = s; start = 1'b1;
  endtask

  task automatic run_seq(input bit use0, input int g, input bit f, input bit s,
                         input int mode, input int abort_after);
    int n_exp, idx, gap_cnt;
    bit expecting, hold, finished, rdy;
    logic [31:0] h_inst;
    logic [ID_W-1:0] h_id, eid;
    sel = use0;
    pat = 0;
    build_exp(use0 ? 0 : 2, g, f, s);
    n_exp = exp_q.size();
    pulse_start(g, f, s);
    idx = 0; gap_cnt = 0; expecting = 0; hold = 0; finished = 0;
    h_inst = '0; h_id = '0;
    for (int t = 0; t < 3000 && !finished; t++) begin
      @(negedge clock);
      start = 1'b0;
      if (idx == n_exp) begin
        check("done_after_exit", 32'(o_done), 32'd1);
        check("busy_after_exit", 32'(o_busy), 32'd0);
        check("valid_after_exit", 32'(o_valid), 32'd0);
        finished = 1;
      end else begin
        if (t == 0) check("first_marker_latency", 32'(o_valid), 32'd1);
        if (o_valid) begin
          if (expecting) check("gap_len", 32'(gap_cnt), f ? 32'd0 : 32'(g));
          expecting = 0;
          if (hold) begin
            check("hold_inst", o_inst, h_inst);
            check("hold_id", 32'(o_id), 32'(h_id));
          end
          eid = ID_W'(idx);
          check("inst", o_inst, exp_q[idx]);
          check("id", 32'(o_id), 32'(eid));
        end else begin
          gap_cnt++;
          check("busy_in_gap", 32'(o_busy), 32'd1);
        end
        rdy = pick_ready(mode);
        out_ready = rdy;
        hold = o_valid && !rdy;
        h_inst = o_inst; h_id = o_id;
        if (o_valid && rdy) begin
          $display("beat %0d inst=0x%08h id=%0d", idx, o_inst, o_id);
          if (idx == abort_after) begin
            @(negedge clock);
            check("gap_before_abort", 32'(o_valid), 32'd0);
            abort = 1'b1; out_ready = 1'b1;
            @(negedge clock);
            abort = 1'b0;
            check("abort_valid", 32'(o_valid), 32'd0);
            check("abort_busy", 32'(o_busy), 32'd0);
            check("abort_done", 32'(o_done), 32'd0);
            @(negedge clock);
            check("abort_stays_idle", 32'(o_valid), 32'd0);
            finished = 1;
          end
          idx++; expecting = 1; gap_cnt = 0;
        end
      end
    end
    if (!finished) check("timeout", 32'(idx), 32'(n_exp));
  endtask

  task automatic reset_test();
    sel = 1'b0;
    build_exp(2, 0, 1'b0, 1'b0);
    pulse_start(0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    out_ready = 1'b0; start = 1'b1;   // start while busy must be ignored
    @(negedge clock); start = 1'b0;
    check("busy_start_id", 32'(o_id), 32'd2);
    check("busy_start_inst", o_inst, exp_q[2]);
    @(negedge clock);
    check("stall_id", 32'(o_id), 32'd2);
    check("stall_valid", 32'(o_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_inst", o_inst, 32'd0);
    check("async_rst_id", 32'(o_id), 32'd0);
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_done", 32'(o_done), 32'd0);
    @(negedge clock); reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("idle_after_reset", 32'(o_valid), 32'd0);
    end
  endtask

  initial begin
    #1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_id", 32'(o_id), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    check("no_emit_without_start", 32'(o_valid), 32'd0);

    run_seq(1'b0, 0, 1'b0, 1'b0, 0, -1);   // back-to-back full sequence
    run_seq(1'b0, 3, 1'b1, 1'b1, 0, -1);   // fillers, skip delay
    run_seq(1'b0, 2, 1'b0, 1'b0, 1, -1);   // idle gaps with 1-0-0 ready
    run_seq(1'b0, 2, 1'b0, 1'b0, 0, 9);    // abort after TEXE_START
    run_seq(1'b0, 0, 1'b0, 1'b0, 2, -1);   // restart from INIT_START
    reset_test();
    run_seq(1'b1, 0, 1'b0, 1'b0, 0, -1);   // no train section
    run_seq(1'b1, 2, 1'b1, 1'b0, 2, -1);
    for (int r = 0; r < 12; r++) begin
      run_seq(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
